// File: rtl/mc_ctrl_if.sv
// Control-bus bundle between the multi-cycle controller (master) and the MIPS datapath (slave).
interface mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      instr;
    logic             Zero;
    logic             mem_ready;
    logic             IRWrite;
    logic             PCWrite;
    logic [1:0]       NPCOp;
    logic             RegWrite;
    logic [1:0]       EXTOp;
    logic [3:0]       ALUOp;
    logic             MemWrite;
    logic [1:0]       RegA3Sel;
    logic [1:0]       RegDataSel;
    logic [1:0]       AluBSel;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  instr, Zero, mem_ready,
        output IRWrite, PCWrite, NPCOp, RegWrite, EXTOp, ALUOp, MemWrite,
               RegA3Sel, RegDataSel, AluBSel, state, illegal, retired
    );

    modport slave (
        output instr, Zero, mem_ready,
        input  IRWrite, PCWrite, NPCOp, RegWrite, EXTOp, ALUOp, MemWrite,
               RegA3Sel, RegDataSel, AluBSel, state, illegal, retired
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXE/MEM/WB sequencing, combinational decode of IR,
// state-gated write enables (final cycle always carries PCWrite), retired-instruction counter.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_JR, I_NOP, I_ILL
    } instr_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;
    instr_t           w_kind;
    logic [5:0]       w_op;
    logic [5:0]       w_fn;
    logic             w_irwrite;
    logic             w_pcwrite;
    logic             w_regwrite;
    logic             w_memwrite;
    logic             w_illegal;
    logic             w_unused;

    assign w_op     = bus.instr[31:26];
    assign w_fn     = bus.instr[5:0];
    // Branch resolution on Zero happens in the NPC unit, not here.
    assign w_unused = bus.Zero;

    always_comb begin
        w_kind = I_ILL;
        if (bus.instr == 32'd0) begin
            w_kind = I_NOP;
        end else begin
            case (w_op)
                6'h00: begin
                    case (w_fn)
                        6'h21:   w_kind = I_ADDU;
                        6'h23:   w_kind = I_SUBU;
                        6'h08:   w_kind = I_JR;
                        default: w_kind = I_ILL;
                    endcase
                end
                6'h0d:   w_kind = I_ORI;
                6'h0f:   w_kind = I_LUI;
                6'h23:   w_kind = I_LW;
                6'h2b:   w_kind = I_SW;
                6'h04:   w_kind = I_BEQ;
                6'h02:   w_kind = I_J;
                6'h03:   w_kind = I_JAL;
                default: w_kind = I_ILL;
            endcase
        end
    end

    always_comb begin
        bus.NPCOp      = 2'b00;
        bus.EXTOp      = 2'b00;
        bus.ALUOp      = 4'b0000;
        bus.RegA3Sel   = 2'b00;
        bus.RegDataSel = 2'b00;
        bus.AluBSel    = 2'b00;
        if (r_state != S_FETCH) begin
            case (w_kind)
                I_SUBU: bus.ALUOp = 4'b0001;
                I_ORI: begin
                    bus.ALUOp    = 4'b0010;
                    bus.AluBSel  = 2'b01;
                    bus.RegA3Sel = 2'b01;
                end
                I_LUI: begin
                    bus.EXTOp      = 2'b10;
                    bus.RegA3Sel   = 2'b01;
                    bus.RegDataSel = 2'b10;
                end
                I_LW: begin
                    bus.EXTOp      = 2'b01;
                    bus.AluBSel    = 2'b01;
                    bus.RegA3Sel   = 2'b01;
                    bus.RegDataSel = 2'b01;
                end
                I_SW: begin
                    bus.EXTOp   = 2'b01;
                    bus.AluBSel = 2'b01;
                end
                I_BEQ: begin
                    bus.NPCOp = 2'b01;
                    bus.ALUOp = 4'b0001;
                end
                I_J:  bus.NPCOp = 2'b10;
                I_JAL: begin
                    bus.NPCOp      = 2'b10;
                    bus.RegA3Sel   = 2'b10;
                    bus.RegDataSel = 2'b11;
                end
                I_JR:    bus.NPCOp = 2'b11;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        w_illegal  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH:  w_irwrite = 1'b1;
                S_DECODE: begin
                    w_pcwrite = (w_kind == I_J) || (w_kind == I_NOP) || (w_kind == I_ILL);
                    w_illegal = (w_kind == I_ILL);
                end
                S_EXE:    w_pcwrite = (w_kind == I_BEQ) || (w_kind == I_JR);
                S_MEM: begin
                    w_memwrite = bus.mem_ready && (w_kind == I_SW);
                    w_pcwrite  = bus.mem_ready && (w_kind == I_SW);
                end
                S_WB: begin
                    w_regwrite = 1'b1;
                    w_pcwrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            if (w_pcwrite) r_retired <= r_retired + CNT_W'(1);
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_kind)
                        I_J, I_NOP, I_ILL: r_state <= S_FETCH;
                        I_JAL:             r_state <= S_WB;
                        default:           r_state <= S_EXE;
                    endcase
                end
                S_EXE: begin
                    case (w_kind)
                        I_BEQ, I_JR: r_state <= S_FETCH;
                        I_LW, I_SW:  r_state <= S_MEM;
                        default:     r_state <= S_WB;
                    endcase
                end
                S_MEM:   if (bus.mem_ready) r_state <= (w_kind == I_SW) ? S_FETCH : S_WB;
                S_WB:    r_state <= S_FETCH;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign bus.IRWrite  = w_irwrite;
    assign bus.PCWrite  = w_pcwrite;
    assign bus.RegWrite = w_regwrite;
    assign bus.MemWrite = w_memwrite;
    assign bus.illegal  = w_illegal;
    assign bus.state    = r_state;
    assign bus.retired  = r_retired;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction state-path model plus per-cycle output compare.
module tb_mc_ctrl;
    localparam int CW = 3;

    typedef enum int {
        K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_NOP, K_ILL
    } kind_t;

    typedef struct {
        logic [31:0] ins;
        kind_t       k;
        int          wt;
        int          rst_at;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_ctrl_if #(.CNT_W(CW)) bus();
    mc_ctrl #(.CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic          e_vld = 1'b0;
    logic [2:0]    e_state;
    logic          e_irw, e_pcw, e_rw, e_mw, e_ill;
    logic [13:0]   e_fld;
    logic [CW-1:0] e_ret;

    // Decoded fields {NPCOp, EXTOp, ALUOp, RegA3Sel, RegDataSel, AluBSel} per mnemonic.
    function automatic logic [13:0] fields(kind_t k);
        case (k)
            K_SUBU:  return {2'd0, 2'd0, 4'd1, 2'd0, 2'd0, 2'd0};
            K_ORI:   return {2'd0, 2'd0, 4'd2, 2'd1, 2'd0, 2'd1};
            K_LUI:   return {2'd0, 2'd2, 4'd0, 2'd1, 2'd2, 2'd0};
            K_LW:    return {2'd0, 2'd1, 4'd0, 2'd1, 2'd1, 2'd1};
            K_SW:    return {2'd0, 2'd1, 4'd0, 2'd0, 2'd0, 2'd1};
            K_BEQ:   return {2'd1, 2'd0, 4'd1, 2'd0, 2'd0, 2'd0};
            K_J:     return {2'd2, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0};
            K_JAL:   return {2'd2, 2'd0, 4'd0, 2'd2, 2'd3, 2'd0};
            K_JR:    return {2'd3, 2'd0, 4'd0, 2'd0, 2'd0, 2'd0};
            default: return 14'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (e_vld) begin
            logic [24:0] got, exp;
            got = {bus.state, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.illegal,
                   bus.NPCOp, bus.EXTOp, bus.ALUOp, bus.RegA3Sel, bus.RegDataSel, bus.AluBSel,
                   bus.retired};
            exp = {e_state, e_irw, e_pcw, e_rw, e_mw, e_ill, e_fld, e_ret};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got st=%0d irw/pcw/rw/mw/ill=%b%b%b%b%b fld=%h ret=%0d exp st=%0d irw/pcw/rw/mw/ill=%b%b%b%b%b fld=%h ret=%0d",
                         $time, bus.state, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite,
                         bus.illegal, got[16:3], bus.retired, e_state, e_irw, e_pcw, e_rw, e_mw,
                         e_ill, e_fld, e_ret);
            end
        end
    end

    vec_t vecs[17];

    initial begin
        int            path[$];
        logic [CW-1:0] model_ret;
        int            lat_got;
        logic          last, rst;

        vecs[0]  = '{32'h34010005, K_ORI,  0, -1, 4};
        vecs[1]  = '{32'h00221821, K_ADDU, 0, -1, 4};
        vecs[2]  = '{32'h00221823, K_SUBU, 0, -1, 4};
        vecs[3]  = '{32'h8C040000, K_LW,   3, -1, 8};
        vecs[4]  = '{32'hAC040004, K_SW,   2, -1, 6};
        vecs[5]  = '{32'h10000001, K_BEQ,  0, -1, 3};
        vecs[6]  = '{32'h08000C00, K_J,    0, -1, 2};
        vecs[7]  = '{32'h0C000C00, K_JAL,  0, -1, 3};
        vecs[8]  = '{32'h03E00008, K_JR,   0, -1, 3};
        vecs[9]  = '{32'hFC000000, K_ILL,  0, -1, 2};
        vecs[10] = '{32'h00000000, K_NOP,  0, -1, 2};
        vecs[11] = '{32'h3C011234, K_LUI,  0, -1, 4};
        vecs[12] = '{32'h8C040000, K_LW,   0, -1, 5};
        vecs[13] = '{32'hAC040004, K_SW,   0, -1, 4};
        vecs[14] = '{32'h00221821, K_ADDU, 0,  2, 0};
        vecs[15] = '{32'h00221821, K_ADDU, 0,  3, 0};
        vecs[16] = '{32'h0000003F, K_ILL,  0, -1, 2};

        reset         = 1'b1;
        bus.instr     = 32'h34010005;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        n_tests++;
        if ({bus.state, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.illegal, bus.retired} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got st=%0d irw=%b pcw=%b ret=%0d exp all zero",
                     bus.state, bus.IRWrite, bus.PCWrite, bus.retired);
        end

        model_ret = '0;
        for (int pass = 0; pass < 3; pass++) begin
            for (int vi = 0; vi < 17; vi++) begin
                path.delete();
                path.push_back(0);
                path.push_back(1);
                case (vecs[vi].k)
                    K_BEQ, K_JR: path.push_back(2);
                    K_JAL:       path.push_back(4);
                    K_ADDU, K_SUBU, K_ORI, K_LUI: begin
                        path.push_back(2);
                        path.push_back(4);
                    end
                    K_LW, K_SW: begin
                        path.push_back(2);
                        for (int w = 0; w <= vecs[vi].wt; w++) path.push_back(3);
                        if (vecs[vi].k == K_LW) path.push_back(4);
                    end
                    default: ;
                endcase

                lat_got = 0;
                for (int k = 0; k < path.size(); k++) begin
                    @(posedge clk);
                    #1;
                    last          = (k == path.size() - 1);
                    rst           = (k == vecs[vi].rst_at);
                    reset         = rst;
                    bus.instr     = vecs[vi].ins;
                    bus.Zero      = (vecs[vi].k == K_BEQ) ? 1'b1 : 1'($urandom_range(0, 1));
                    if (path[k] == 3)
                        bus.mem_ready = (k + 1 == path.size()) || (path[k+1] != 3);
                    else
                        bus.mem_ready = 1'($urandom_range(0, 1));

                    e_state = 3'(path[k]);
                    e_irw   = (k == 0) && !rst;
                    e_pcw   = last && !rst;
                    e_rw    = (path[k] == 4) && !rst;
                    e_mw    = (vecs[vi].k == K_SW) && last && !rst;
                    e_ill   = (vecs[vi].k == K_ILL) && (path[k] == 1) && !rst;
                    e_fld   = (path[k] == 0) ? 14'd0 : fields(vecs[vi].k);
                    e_ret   = model_ret;
                    e_vld   = 1'b1;

                    #3;
                    if (bus.PCWrite && lat_got == 0) lat_got = k + 1;
                    if (rst) begin
                        model_ret = '0;
                        break;
                    end
                    if (e_pcw) model_ret = model_ret + CW'(1);
                end

                n_tests++;
                if (lat_got != vecs[vi].lat) begin
                    n_fail++;
                    $display("FAIL latency vec=%0d instr=%h got %0d cycles exp %0d",
                             vi, vecs[vi].ins, lat_got, vecs[vi].lat);
                end
            end
        end

        @(negedge clk);
        #1;
        e_vld = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle controller FSM that sequences the single-cycle MIPS datapath split into FETCH/DECODE/EXE/MEM/WB steps. Decodes the latched instruction register. Drives the existing datapath control buses (NPCOp, RegWrite, EXTOp, ALUOp, MemWrite, RegA3Sel, RegDataSel, AluBSel) plus IR and PC write enables. Keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
instr  input  32  current IR contents (opcode [31:26], funct [5:0])
Zero  input  1  ALU equality flag (beq)
mem_ready  input  1  data memory ready; sampled only in MEM
IRWrite  output  1  latch IM output into IR
PCWrite  output  1  update PC with NPC
NPCOp  output  2  00 PC+4, 01 beq (taken iff Zero), 10 j/jal target, 11 jr (RD1)
RegWrite  output  1  GRF write enable
EXTOp  output  2  00 zero-ext, 01 sign-ext, 10 imm<<16
ALUOp  output  4  0000 add, 0001 sub, 0010 or
MemWrite  output  1  DM write enable
RegA3Sel  output  2  00 rd, 01 rt, 10 $31
RegDataSel  output  2  00 ALU, 01 DM, 10 Ext, 11 PC4
AluBSel  output  2  00 RD2, 01 Ext
state  output  3  FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4
illegal  output  1  one-cycle pulse in DECODE on unsupported instruction
retired  output  CNT_W  count of completed instructions

Behaviour:
- Reset (reset=1 at posedge): state<=FETCH, retired<=0. While reset=1, IRWrite/PCWrite/RegWrite/MemWrite/illegal forced 0.
- Decoded fields (NPCOp, EXTOp, ALUOp, RegA3Sel, RegDataSel, AluBSel) are combinational from instr. They are valid in every state except FETCH. In FETCH and for illegal/nop they are all 0.
- Write enables are gated by state as listed below. Outside the listed cycles they are 0.
- FETCH: IRWrite=1; next DECODE.
- DECODE: j: PCWrite=1 (NPCOp=10) -> FETCH. nop (instr==0) or illegal: PCWrite=1 (NPCOp=00), illegal pulses for illegal -> FETCH. jal -> WB. Others -> EXE.
- EXE: beq: ALUOp=sub, PCWrite=1, NPCOp=01 -> FETCH. jr: PCWrite=1, NPCOp=11 -> FETCH. lw/sw -> MEM. addu/subu/ori/lui -> WB.
- MEM: stay while mem_ready=0, with all enables 0. When mem_ready=1: sw: MemWrite=1, PCWrite=1 (NPCOp=00) -> FETCH. lw -> WB.
- WB: RegWrite=1, PCWrite=1 -> FETCH. jal uses NPCOp=10; all others use NPCOp=00.
- Per-instruction decode:
  - addu: ALU add, B=RD2, A3=rd, data=ALU.
  - subu: sub, RD2, rd, ALU.
  - ori: or, EXTOp=00, B=Ext, A3=rt, data=ALU.
  - lui: EXTOp=10, A3=rt, data=Ext.
  - lw: add, EXTOp=01, B=Ext, A3=rt, data=DM.
  - sw: add, EXTOp=01, B=Ext.
  - jal: A3=10, data=PC4, NPCOp=10.
- Latency in cycles: j/nop/illegal 2; beq/jr/jal 3; R-type/ori/lui 4; sw 4+wait; lw 5+wait.
- retired increments by 1 on every posedge where PCWrite=1, wrapping at 2^CNT_W-1 to 0.
- PCWrite is asserted in exactly one cycle per instruction, always the final one. RegWrite and MemWrite are never asserted in the same cycle.
- Reset mid-instruction: abandons the instruction with no write enable asserted in that cycle. Next cycle is FETCH.
- Unknown state encodings (5-7) return to FETCH next cycle with all enables 0.

Test Plan:
- Reset, then ori 0x34010005 -> states 0,1,2,4. In WB: RegWrite=1, RegA3Sel=01, AluBSel=01, EXTOp=00, PCWrite=1. retired=1.
- addu 0x00221821 then subu 0x00221823 -> WB cycle has RegA3Sel=00, RegDataSel=00. ALUOp is 0000 then 0001. retired=2 after 8 cycles.
- lw 0x8C040000 with mem_ready low 3 cycles -> MEM held 3 cycles with no enables, then WB with RegDataSel=01. sw 0xAC040004 -> MemWrite=1 only in the mem_ready cycle.
- beq 0x10000001 with Zero=1 -> EXE has NPCOp=01, PCWrite=1. Total 3 cycles. j 0x08000C00 -> PCWrite in DECODE with NPCOp=10, 2 cycles.
- jal 0x0C000C00 then jr 0x03E00008 -> jal WB: RegA3Sel=10, RegDataSel=11, NPCOp=10. jr EXE: NPCOp=11.
- Illegal opcode 0xFC000000 -> illegal=1 in DECODE, PCWrite NPCOp=00. Reset asserted during EXE of addu -> no RegWrite, state=0 next.
